// File: rtl/mem_access_seq.sv
// Memory access sequencer: serialises fetch and load/store requests onto the
// memory's registered ports and returns a held ready/valid response.
`timescale 1ns/1ps

module mem_access_seq #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [2:0]        ls_funct3,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [ADDR_W-1:0] ls_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [ADDR_W-1:0] resp_data,
    output logic              resp_is_fetch,
    output logic              resp_err,
    output logic              mem_write_mem,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [ADDR_W-1:0] mem_write_data,
    input  logic [ADDR_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [2:0] FETCH_F3 = 3'b010;

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0] resp_data_q, resp_data_d;
    logic              resp_is_fetch_q, resp_is_fetch_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_write_mem_q, mem_write_mem_d;
    logic [2:0]        mem_funct3_q, mem_funct3_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              req_any;
    logic              req_is_fetch;
    logic              req_we;
    logic [2:0]        req_f3;
    logic [ADDR_W-1:0] req_addr;
    logic              req_legal;

    function automatic logic is_legal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] lo);
        logic ok;
        ok = 1'b1;
        case (f3[1:0])
            2'b11:   ok = 1'b0;
            2'b10:   ok = (lo == 2'b00);
            2'b01:   ok = ~lo[0];
            default: ok = 1'b1;
        endcase
        if (we && f3[2])
            ok = 1'b0;
        if (!we && (f3[2:1] == 2'b11))
            ok = 1'b0;
        return ok;
    endfunction

    // Load/store wins arbitration; a losing fetch is simply not acknowledged.
    always_comb begin
        req_any      = ls_req | fetch_req;
        req_is_fetch = ~ls_req;
        req_we       = ls_req & ls_we;
        req_f3       = ls_req ? ls_funct3 : FETCH_F3;
        req_addr     = ls_req ? ls_addr : pc;
        req_legal    = is_legal(req_we, req_f3, req_addr[1:0]);
    end

    always_comb begin
        state_d         = state_q;
        req_ready_d     = req_ready_q;
        resp_valid_d    = resp_valid_q;
        resp_data_d     = resp_data_q;
        resp_is_fetch_d = resp_is_fetch_q;
        resp_err_d      = resp_err_q;
        mem_write_mem_d = 1'b0;
        mem_funct3_d    = mem_funct3_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    req_ready_d     = 1'b0;
                    resp_is_fetch_d = req_is_fetch;
                    resp_data_d     = '0;
                    if (!req_legal) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d         = ISSUE;
                        resp_err_d      = 1'b0;
                        mem_addr_d      = req_addr;
                        mem_wdata_d     = ls_wdata;
                        mem_funct3_d    = req_f3;
                        mem_write_mem_d = req_we;
                    end
                end
            end
            ISSUE: begin
                // The write strobe is only ever high in ISSUE, so it doubles as the store marker.
                if (mem_write_mem_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_data_d  = mem_read_data;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_is_fetch_q <= 1'b0;
            resp_err_q      <= 1'b0;
            mem_write_mem_q <= 1'b0;
            mem_funct3_q    <= 3'b000;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_is_fetch_q <= resp_is_fetch_d;
            resp_err_q      <= resp_err_d;
            mem_write_mem_q <= mem_write_mem_d;
            mem_funct3_q    <= mem_funct3_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
        end
    end

    assign req_ready         = req_ready_q;
    assign resp_valid        = resp_valid_q;
    assign resp_data         = resp_data_q;
    assign resp_is_fetch     = resp_is_fetch_q;
    assign resp_err          = resp_err_q;
    assign mem_write_mem     = mem_write_mem_q;
    assign mem_funct3        = mem_funct3_q;
    assign mem_read_address  = mem_addr_q;
    assign mem_write_address = mem_addr_q;
    assign mem_write_data    = mem_wdata_q;

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Memory access sequencer between the multi-cycle core datapath and the `memory` block. It accepts one instruction-fetch or load/store request at a time and checks alignment and funct3 legality. It drives the memory's read/write address, data, funct3 and write-enable ports with registered signals, absorbs the memory's one-cycle registered read latency, and returns a held response with a ready/valid handshake.

## Interface
Parameters
- `ADDR_W`, 32, address and data width; fixed at 32 for RV32I.

Ports
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  request an instruction fetch from `pc`.
- `pc`  in  32  fetch address.
- `ls_req`  in  1  request a load/store.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_funct3`  in  3  RV32I load/store funct3.
- `ls_addr`  in  32  load/store byte address.
- `ls_wdata`  in  32  store data; byte and half data sit in the LSBs.
- `req_ready`  out  1  sequencer idle; a request is accepted on any edge where this signal and a request are both high.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer takes the response.
- `resp_data`  out  32  fetched word or extended load value; 0 for stores and errors.
- `resp_is_fetch`  out  1  response belongs to a fetch.
- `resp_err`  out  1  request was misaligned or illegal; no memory access was made.
- `mem_write_mem`  out  1  to memory `write_mem`.
- `mem_funct3`  out  3  to memory `funct3`.
- `mem_read_address`  out  32  to memory `read_address`.
- `mem_write_address`  out  32  to memory `write_address`.
- `mem_write_data`  out  32  to memory `write_data`.
- `mem_read_data`  in  32  from memory `read_data`; valid the cycle after the edge that samples the address.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - ISSUE: memory ports driven.
  - CAPTURE: `mem_read_data` valid.
  - RESP: `resp_valid`=1.
- Arbitration in IDLE:
  - `ls_req` has priority over `fetch_req`.
  - The losing request is not latched; the requester holds it until accepted.
- Fetches use funct3 3'b010.
- Legality check, done at acceptance on the funct3 and address:
  - Word (funct3[1:0]=10) requires addr[1:0]=00.
  - Half (01) requires addr[0]=0.
  - Byte (00) is always aligned.
  - Illegal: funct3[1:0]=11; loads with funct3 110 or 111; stores with funct3[2]=1.
- Failed check: IDLE→RESP, with `resp_err`=1 and `resp_data`=0. `mem_write_mem` stays 0 and the memory address ports are not updated.
- Legal load or fetch: IDLE→ISSUE→CAPTURE→RESP. At the CAPTURE→RESP edge, `resp_data` ← `mem_read_data`. Sign and zero extension are done by memory.
- Legal store: IDLE→ISSUE→RESP. `mem_write_mem`=1 during ISSUE only; `resp_data`=0.
- Memory-port values are registered at acceptance and held until the next acceptance:
  - `mem_read_address` = `mem_write_address` = request address.
  - `mem_write_data` = `ls_wdata`.
  - `mem_funct3` = request funct3.
- RESP: `resp_data`, `resp_err` and `resp_is_fetch` hold stable while `resp_valid`=1 and `resp_ready`=0.
- RESP→IDLE on the edge where `resp_ready`=1. No request is accepted in that cycle.
- `mem_write_mem` is 0 in every state except ISSUE-of-store. No other path asserts it.

## Timing
- Reset (asynchronous, effective immediately while `rst_n`=0):
  - state = IDLE.
  - `req_ready`=1.
  - `resp_valid`, `resp_err`, `resp_is_fetch`, `mem_write_mem` = 0.
  - All 32-bit outputs and `mem_funct3` = 0.
- Reset asserted during ISSUE-of-store drops `mem_write_mem` before the next edge, so the memory is not written. The pending transaction is discarded; no response is produced.
- Latency, with acceptance on the edge ending cycle 0:
  - Load/fetch: `resp_valid` high from cycle 3.
  - Store: `resp_valid` high from cycle 2; memory written at the edge ending cycle 1.
  - Error: `resp_valid` high from cycle 1.
- Throughput: at most one transaction per 3 cycles (store) or 4 cycles (load), with `resp_ready` tied high.
- Requests presented outside IDLE are ignored; `req_ready`=0 there.
- Address wrap is not applicable; the full 32-bit address is forwarded, and memory decodes peripheral and unmapped ranges.

## Test plan
- Fetch: memory word 0x10 = 0x8000FF7F, `fetch_req`, `pc`=0x10 → `resp_valid` in cycle 3 with `resp_data`=0x8000FF7F, `resp_is_fetch`=1, `resp_err`=0.
- Loads from the same word:
  - lb 0x10 → 0x0000007F.
  - lbu 0x11 → 0x000000FF.
  - lh 0x12 → 0xFFFF8000.
  - lhu 0x12 → 0x00008000.
  - Each response arrives in cycle 3.
- Store then read: sw 0x20 of 0xDEADBEEF → `mem_write_mem` high exactly one cycle, `resp_valid` in cycle 2. A following sb 0x21 of 0x55 and lw 0x20 return 0xDEADBEEF → 0xDEAD55EF.
- Errors: lw 0x22, lh 0x13, and ls_funct3=011 → each gives `resp_err`=1 in cycle 1, `resp_data`=0, `mem_write_mem` never asserted, `mem_read_address` unchanged.
- Handshake: `resp_ready` held low 5 cycles → response fields stable and `req_ready`=0 throughout. `fetch_req` and `ls_req` raised together → load/store served first, fetch served next.
- Reset: `rst_n` pulled low mid-ISSUE of sw 0x30 → all outputs reset immediately, memory word 0x30 unchanged; after release, `req_ready`=1 and a new fetch completes normally.
